// File: rtl/rd_ptr.sv
// rtl/rd_ptr.sv - FIFO read pointer with first-word-fall-through output stage
//
// Tracks the read pointer against the write pointer and issues reads to a
// synchronous-read RAM. The returned words are presented as a valid/ready
// stream. An output register plus a one-entry skid absorb the one-cycle RAM
// latency, so one word per cycle flows under continuous ready.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   i_wptr        write pointer (ALEN+1 bits, MSB is the wrap flag)
//   o_rptr        registered read pointer, fed back to the write side
//   o_raddr       RAM read address (low ALEN bits of o_rptr)
//   o_ram_ren     RAM read enable (combinational)
//   i_ram_rdata   RAM read data, valid the cycle after o_ram_ren
//   o_tvalid      output valid (registered)
//   i_tready      downstream ready
//   o_tdata       output data (registered)
module rd_ptr #(
    parameter int ALEN = 8,
    parameter int DLEN = 8,
    parameter int INCR = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ALEN:0]   i_wptr,
    output logic [ALEN:0]   o_rptr,
    output logic [ALEN-1:0] o_raddr,
    output logic            o_ram_ren,
    input  logic [DLEN-1:0] i_ram_rdata,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [DLEN-1:0] o_tdata
);

    localparam logic [ALEN:0] STEP = (ALEN+1)'(INCR);

    logic            inflight;
    logic            skid_valid;
    logic [DLEN-1:0] skid_data;

    logic            empty;
    logic            pop;
    logic [1:0]      occ;

    // Full-width compare: equal low bits with different MSBs means full, not empty.
    assign empty   = (o_rptr == i_wptr);
    assign pop     = o_tvalid & i_tready;
    assign o_raddr = o_rptr[ALEN-1:0];

    // Words already committed to this stage: in the RAM pipe, in out, in skid.
    assign occ = {1'b0, inflight} + {1'b0, o_tvalid} + {1'b0, skid_valid};

    // A new read is allowed only if its data will have a slot when it returns,
    // counting the slot freed by a pop this cycle. occ >= pop always holds
    // because pop implies o_tvalid.
    assign o_ram_ren = ~empty & ((occ - {1'b0, pop}) < 2'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rptr     <= '0;
            inflight   <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            inflight <= o_ram_ren;
            if (o_ram_ren) begin
                o_rptr <= o_rptr + STEP;
            end

            if (pop) begin
                if (skid_valid) begin
                    // Skid holds the older word, so it moves to out first;
                    // a word returning now backfills the skid.
                    o_tdata <= skid_data;
                    if (inflight) begin
                        skid_data <= i_ram_rdata;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (inflight) begin
                    o_tdata <= i_ram_rdata;
                end else begin
                    o_tvalid <= 1'b0;
                end
            end else if (o_tvalid) begin
                // Out is stalled; a returning word parks in the skid. The issue
                // rule guarantees the skid is free whenever a return arrives here.
                if (inflight) begin
                    skid_valid <= 1'b1;
                    skid_data  <= i_ram_rdata;
                end
            end else if (inflight) begin
                o_tvalid <= 1'b1;
                o_tdata  <= i_ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_rd_ptr.sv
// tb/tb_rd_ptr.sv - self-checking bench for rd_ptr with a RAM and write-side model
module tb_rd_ptr;

    localparam int ALEN  = 2;
    localparam int DLEN  = 8;
    localparam int INCR  = 1;
    localparam int DEPTH = 1 << ALEN;

    logic            clk = 1'b0;
    logic            rstn;
    logic [ALEN:0]   wptr;
    logic [ALEN:0]   rptr;
    logic [ALEN-1:0] raddr;
    logic            ren;
    logic [DLEN-1:0] rdata;
    logic            tvalid;
    logic            tready;
    logic [DLEN-1:0] tdata;

    logic [DLEN-1:0] mem [DEPTH];
    logic [DLEN-1:0] exp_q [$];

    int  errors = 0;
    int  checks = 0;
    int  nwritten, nissue, npop;
    bit  ren_pend, pop_pend;

    rd_ptr #(.ALEN(ALEN), .DLEN(DLEN), .INCR(INCR)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wptr      (wptr),
        .o_rptr      (rptr),
        .o_raddr     (raddr),
        .o_ram_ren   (ren),
        .i_ram_rdata (rdata),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_tdata     (tdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
    end

    task automatic model_reset();
        wptr     = '0;
        exp_q.delete();
        nwritten = 0;
        nissue   = 0;
        npop     = 0;
        ren_pend = 1'b0;
        pop_pend = 1'b0;
    endtask

    function automatic bit has_room();
        return (3'(wptr - rptr) < 3'(DEPTH));
    endfunction

    // One clock: optionally write a word, set ready, then sample at negedge.
    // nissue/npop count transfers completed at past edges, so at the sample
    // point rptr should equal nissue and the stage occupancy is nissue-npop.
    task automatic tick(input bit wr, input logic [DLEN-1:0] d, input bit rdy,
                        output bit popped, output logic [DLEN-1:0] exp_d);
        @(posedge clk);
        #1;
        if (wr) begin
            mem[wptr[ALEN-1:0]] = d;
            wptr = wptr + 1'b1;
            exp_q.push_back(d);
            nwritten++;
        end
        tready = rdy;
        @(negedge clk);
        if (ren_pend) nissue++;
        if (pop_pend) npop++;
        popped = tvalid & tready;
        exp_d  = 'x;
        if (popped && exp_q.size() > 0) exp_d = exp_q.pop_front();
        ren_pend = ren;
        pop_pend = popped;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        tready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rptr !== '0)   $display("FAIL reset_rptr: got %0h expected 0", rptr);
        if (rptr !== '0) errors++;
        checks++; if (raddr !== '0)  begin errors++; $display("FAIL reset_raddr: got %0h expected 0", raddr); end
        checks++; if (tvalid !== 0)  begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", tvalid); end
        checks++; if (tdata !== '0)  begin errors++; $display("FAIL reset_tdata: got %0h expected 0", tdata); end
        checks++; if (ren !== 0)     begin errors++; $display("FAIL reset_ren: got %0b expected 0", ren); end
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit p; logic [DLEN-1:0] e;
            tick(1'b0, '0, 1'b0, p, e);
            checks++;
            if (tvalid !== 0 || ren !== 0 || rptr !== '0) begin
                errors++;
                $display("FAIL reset_idle: got tvalid=%0b ren=%0b rptr=%0h expected 0/0/0", tvalid, ren, rptr);
            end
        end
    endtask

    task automatic test_single();
        bit p; logic [DLEN-1:0] e;
        tick(1'b1, 8'hA5, 1'b0, p, e);
        checks++; if (ren !== 1 || rptr !== 3'd0) begin errors++; $display("FAIL single_issue: got ren=%0b rptr=%0h expected 1/0", ren, rptr); end
        tick(1'b0, '0, 1'b0, p, e);
        checks++; if (ren !== 0 || rptr !== 3'd1 || tvalid !== 0) begin errors++; $display("FAIL single_e1: got ren=%0b rptr=%0h tvalid=%0b expected 0/1/0", ren, rptr, tvalid); end
        tick(1'b0, '0, 1'b1, p, e);
        checks++; if (tvalid !== 1 || tdata !== 8'hA5) begin errors++; $display("FAIL single_data: got tvalid=%0b tdata=%0h expected 1/a5", tvalid, tdata); end
        checks++; if (!p || e !== 8'hA5) begin errors++; $display("FAIL single_model: got popped=%0b exp=%0h expected 1/a5", p, e); end
        tick(1'b0, '0, 1'b0, p, e);
        checks++; if (tvalid !== 0 || rptr !== 3'd1) begin errors++; $display("FAIL single_after_pop: got tvalid=%0b rptr=%0h expected 0/1", tvalid, rptr); end
    endtask

    task automatic test_backpressure();
        bit p; logic [DLEN-1:0] e;
        for (int i = 0; i < 4; i++) tick(1'b1, DLEN'(8'h10 + i), 1'b0, p, e);
        repeat (3) tick(1'b0, '0, 1'b0, p, e);
        checks++; if (rptr !== 3'd3) begin errors++; $display("FAIL bp_rptr: got %0h expected 3", rptr); end
        checks++; if (tvalid !== 1 || tdata !== 8'h10) begin errors++; $display("FAIL bp_hold: got tvalid=%0b tdata=%0h expected 1/10", tvalid, tdata); end
        checks++; if (nissue - npop !== 2) begin errors++; $display("FAIL bp_outstanding: got %0d expected 2", nissue - npop); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, p, e);
            checks++;
            if (!p || tdata !== DLEN'(8'h10 + i) || tdata !== e) begin
                errors++;
                $display("FAIL bp_drain%0d: got valid=%0b tdata=%0h expected 1/%0h", i, tvalid, tdata, 8'h10 + i);
            end
        end
        tick(1'b0, '0, 1'b0, p, e);
        checks++; if (tvalid !== 0 || rptr !== 3'd5) begin errors++; $display("FAIL bp_end: got tvalid=%0b rptr=%0h expected 0/5", tvalid, rptr); end
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0;
        bit saw_msb = 0, saw_zero = 0;
        logic [ALEN:0] prev = rptr;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            bit p; logic [DLEN-1:0] e;
            bit wr = (sent < 10) && has_room();
            tick(wr, DLEN'($urandom), 1'b1, p, e);
            if (wr) sent++;
            if (p) begin
                got++;
                checks++; if (tdata !== e) begin errors++; $display("FAIL wrap_data: got %0h expected %0h", tdata, e); end
            end
            checks++; if (rptr !== 3'(nissue)) begin errors++; $display("FAIL wrap_rptr: got %0h expected %0h", rptr, 3'(nissue)); end
            checks++; if (ren && nissue >= nwritten) begin errors++; $display("FAIL wrap_overread: got issued=%0d expected below written=%0d", nissue, nwritten); end
            if (prev == 3'd3 && rptr == 3'd4) saw_msb = 1;
            if (prev == 3'd7 && rptr == 3'd0) saw_zero = 1;
            prev = rptr;
        end
        checks++; if (got != 10) begin errors++; $display("FAIL wrap_count: got %0d expected 10", got); end
        checks++; if (!saw_msb || !saw_zero) begin errors++; $display("FAIL wrap_seen: got msb=%0b zero=%0b expected 1/1", saw_msb, saw_zero); end
        checks++; if (rptr !== wptr) begin errors++; $display("FAIL wrap_final: got rptr=%0h expected %0h", rptr, wptr); end
    endtask

    task automatic test_random_stall();
        bit stall = 0;
        logic [DLEN-1:0] held = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            bit p; logic [DLEN-1:0] e;
            bit wr = ($urandom_range(3) != 0) && has_room();
            tick(wr, DLEN'($urandom), 1'($urandom_range(1)), p, e);
            if (p) begin
                checks++; if (tdata !== e) begin errors++; $display("FAIL rnd_data: got %0h expected %0h", tdata, e); end
            end
            if (stall) begin
                checks++; if (tvalid !== 1 || tdata !== held) begin errors++; $display("FAIL rnd_hold: got tvalid=%0b tdata=%0h expected 1/%0h", tvalid, tdata, held); end
            end
            checks++; if (nissue - npop > 2 || nissue < npop) begin errors++; $display("FAIL rnd_occ: got %0d expected 0..2", nissue - npop); end
            checks++; if (rptr !== 3'(nissue)) begin errors++; $display("FAIL rnd_rptr: got %0h expected %0h", rptr, 3'(nissue)); end
            checks++; if (ren && nissue >= nwritten) begin errors++; $display("FAIL rnd_overread: got issued=%0d expected below written=%0d", nissue, nwritten); end
            stall = tvalid & ~tready;
            held  = tdata;
        end
        for (int cyc = 0; cyc < 40 && (exp_q.size() > 0 || tvalid); cyc++) begin
            bit p; logic [DLEN-1:0] e;
            tick(1'b0, '0, 1'b1, p, e);
            if (p) begin
                checks++; if (tdata !== e) begin errors++; $display("FAIL rnd_drain: got %0h expected %0h", tdata, e); end
            end
        end
        checks++; if (exp_q.size() != 0 || tvalid !== 0 || npop + (pop_pend ? 1 : 0) != nwritten) begin
            errors++; $display("FAIL rnd_drained: got left=%0d tvalid=%0b expected 0/0", exp_q.size(), tvalid);
        end
    endtask

    task automatic test_async_reset();
        bit p; logic [DLEN-1:0] e;
        for (int i = 0; i < 3; i++) tick(1'b1, DLEN'(8'h50 + i), 1'b0, p, e);
        for (int cyc = 0; cyc < 10 && !tvalid; cyc++) tick(1'b0, '0, 1'b0, p, e);
        checks++; if (tvalid !== 1) begin errors++; $display("FAIL arst_pre: got tvalid=%0b expected 1", tvalid); end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (tvalid !== 0 || rptr !== '0 || ren !== 0) begin
            errors++; $display("FAIL arst_now: got tvalid=%0b rptr=%0h ren=%0b expected 0/0/0", tvalid, rptr, ren);
        end
        @(posedge clk);
        #1 rstn = 1'b1;
        tick(1'b0, '0, 1'b0, p, e);
        checks++; if (tvalid !== 0 || rptr !== '0) begin errors++; $display("FAIL arst_idle: got tvalid=%0b rptr=%0h expected 0/0", tvalid, rptr); end
        tick(1'b1, 8'h3C, 1'b1, p, e);
        tick(1'b0, '0, 1'b1, p, e);
        tick(1'b0, '0, 1'b1, p, e);
        checks++; if (!p || tdata !== 8'h3C || e !== 8'h3C) begin
            errors++; $display("FAIL arst_resume: got valid=%0b tdata=%0h expected 1/3c", tvalid, tdata);
        end
    endtask

    initial begin
        rdata  = '0;
        wptr   = '0;
        tready = 1'b0;
        rstn   = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_random_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rd_ptr.md
# rd_ptr

Read-side pointer and output stage for the FIFO, the counterpart of the write-pointer block on the same RAM. It tracks the read pointer against the write pointer, issues reads to the synchronous-read RAM, and presents data as a first-word-fall-through AXI-Stream-style source. A two-entry holding stage covers the one-cycle RAM read latency, so the block sustains one transfer per cycle under continuous `i_tready`.

## Interface
- `ALEN`, 8: address width; FIFO depth is 2^ALEN; pointers are ALEN+1 bits.
- `DLEN`, 8: data width.
- `INCR`, 1: pointer increment per read; equals the write side's INCR.

- `clk` input 1: single clock; all logic on its rising edge.
- `rstn` input 1: reset, asynchronous assert, active-low.
- `i_wptr` input ALEN+1: write pointer from the write side, same clock domain.
- `o_rptr` output ALEN+1: registered read pointer, fed back to the write side.
- `o_raddr` output ALEN: RAM read address, equal to `o_rptr[ALEN-1:0]`.
- `o_ram_ren` output 1: RAM read enable, combinational.
- `i_ram_rdata` input DLEN: RAM read data, valid the cycle after `o_ram_ren`.
- `o_tvalid` output 1: output data valid, registered.
- `i_tready` input 1: downstream ready.
- `o_tdata` output DLEN: output data, registered.

## Operation
- **Empty.** `empty = (o_rptr == i_wptr)`, a full (ALEN+1)-bit compare. The MSB distinguishes a wrapped pointer.
- **Pop.** `pop = o_tvalid & i_tready`.
- **State registers.**
  - `inflight`: a read was issued last cycle.
  - `out_valid`: drives `o_tvalid`.
  - `skid_valid`, with `skid_data`.
- **Occupancy.** `occ = inflight + out_valid + skid_valid`. Invariant: `occ <= 2`.
- **Issue.** `o_ram_ren = ~empty & ((occ - pop) < 2)`. It never asserts while empty.
- **Pointer.** On `o_ram_ren`, `o_rptr <= o_rptr + INCR`, modulo 2^(ALEN+1). Otherwise it holds.
- **Data routing each edge (`ret = inflight`).**
  - If `pop`:
    - `skid_valid`: out takes the skid entry. If `ret` is also set, the skid loads `i_ram_rdata`; otherwise `skid_valid` clears.
    - Else if `ret`: out loads `i_ram_rdata`.
    - Else: `out_valid` clears.
  - If no `pop` and `out_valid`: `ret` loads the skid. `ret` with `skid_valid` already set cannot occur.
  - If no `pop` and not `out_valid`: `ret` loads out.
- **Ordering.** Data leaves in strict write order. No entry is dropped or duplicated.
- **Handshake.**
  - Once `o_tvalid` is high, it and `o_tdata` hold until `pop`.
  - `o_tvalid` does not depend combinationally on `i_tready`.
- **Write/read hazard.** A read of an entry happens no earlier than the cycle after its `i_wptr` update, so no RAM write-through is needed.

## Timing
- **Reset values** (asynchronous, while `rstn` = 0):
  - `o_rptr` = 0, `o_raddr` = 0.
  - `o_tvalid` = 0, `o_tdata` = 0.
  - `inflight`, `skid_valid`, `skid_data` = 0.
  - `o_ram_ren` = 0, because the pointers are equal after reset with `i_wptr` = 0.
- **Reset mid-operation.** `o_tvalid` drops without waiting for a clock edge. Held and in-flight data are discarded.
- **Latency.** When `i_wptr` advances at edge E0:
  - `o_ram_ren` is high in the following cycle.
  - `o_rptr` advances at E1.
  - `o_tvalid` rises after E2 (2 cycles).
- **Throughput.** One pop per cycle while not empty and `i_tready` is high.
- **Backpressure.** With `i_tready` low, at most 2 reads are outstanding beyond the last pop: one in the out register and one in the skid.
- **Wrap.** The `o_raddr` wrap 2^ALEN-1 → 0 toggles `o_rptr[ALEN]`. Empty detection stays correct across a wrap.
- **Simultaneous events.**
  - A write and a read in the same cycle are independent. `i_wptr` changes take effect on empty in the next cycle.
  - A pop and a return in the same cycle keep `occ` consistent.

## Test plan
- **Reset.** Hold `rstn` low for 3 cycles → `o_rptr`=0, `o_tvalid`=0, `o_ram_ren`=0. With `i_wptr` held at 0 after release, outputs stay idle.
- **Single word.** Write 0xA5, `i_wptr` 0→1 at E0 → `o_ram_ren` pulses for one cycle, `o_rptr`=1 at E1, `o_tvalid`=1 with `o_tdata`=0xA5 after E2. A pop with `i_tready`=1 → `o_tvalid`=0 next cycle.
- **Backpressure.** Write 4 words 0x10–0x13 with `i_tready`=0 → exactly 2 reads issue, `o_rptr`=2, `o_tdata` holds 0x10. Then set `i_tready`=1 → 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles, `o_rptr`=4, then `o_tvalid`=0.
- **Wrap.** With `ALEN`=2, stream 10 words through with continuous ready → data in order, `o_rptr` passes 3→4 (MSB set) and 7→0, no spurious empty or overread.
- **Random stall.** Continuous writer, random `i_tready` at 50% → scoreboard matches, `occ` never exceeds 2, `o_tdata` stable while stalled.
- **Async reset.** Assert `rstn` low mid-stream with `o_tvalid`=1 → `o_tvalid`=0 and `o_rptr`=0 before the next clock edge.
